div_sequencer: RTL and testbench

//  Multi-cycle sequencer for DIV/DIVU issued from the decode stage (isDiv, funct 01101x).

---
 rtl/mips_defs_pkg.sv | 14 +
 rtl/div_step.sv | 29 ++
 rtl/div_sequencer.sv | 127 ++++++++++++
 tb/tb_div_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode/execute definitions used by the divide sequencer.
package mips_defs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [7:0] EXE_ZERO_OP = 8'h00;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring divide step: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits, record the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The extra top bit keeps the shifted remainder exact when the divisor uses the full width.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_i};
        if (trial[WIDTH]) begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer with pipeline stall, HILO write strobe and flush abort.
// Optional macro DIV_ZERO_EARLY_EN: a zero divisor skips the iterations and finishes in one cycle.
module div_sequencer
    import mips_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             accept;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_nx),
        .quo_o  (quo_nx)
    );

    assign accept = (state_q == IDLE) && start && !annul;
    assign stall  = accept || (state_q == BUSY);
    assign ready  = (state_q == DONE) && !annul;
    assign hi     = hi_q;
    assign lo     = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = BUSY;
                    rem_d     = '0;
                    quo_d     = magnitude(opa, signed_div);
                    dvsr_d    = magnitude(opb, signed_div);
                    sgn_quo_d = signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    sgn_rem_d = signed_div && opa[WIDTH-1];
`ifdef DIV_ZERO_EARLY_EN
                    if (opb == '0) begin
                        state_d = DONE;
                        hi_d    = opa;
                        lo_d    = '1;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                // Result registers load on the last iteration so hi/lo are valid alongside ready.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    hi_d    = sgn_rem_q ? -rem_nx : rem_nx;
                    lo_d    = sgn_quo_q ? -quo_nx : quo_nx;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (annul) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random operands
// against a magnitude/sign arithmetic reference model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opa        (opa),
        .opb        (opb),
        .stall      (stall),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating division on magnitudes, then sign of quotient = sa^sb, sign of remainder = sa.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        logic [63:0] ma, mb, qq, rr;
        bit na, nb;
        na  = sgn && a[31];
        nb  = sgn && b[31];
        ma  = na ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        mb  = nb ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
        lat = 33;
        if (mb == 0) begin
            qq = 64'hFFFF_FFFF;
            rr = ma;
        end else begin
            qq = ma / mb;
            rr = ma % mb;
        end
        q = (na ^ nb) ? 32'(-qq) : qq[31:0];
        r = na ? 32'(-rr) : rr[31:0];
`ifdef DIV_ZERO_EARLY_EN
        if (b == 32'h0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 1;
        end
`endif
    endfunction

    // Full transaction: start in cycle 0, then follow stall/ready cycle by cycle.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit sgn, input bit hold);
        logic [31:0] eq, er;
        int lat;
        bit seen;
        ref_div(a, b, sgn, eq, er, lat);
        @(negedge clk);
        start = 1'b1; opa = a; opb = b; signed_div = sgn;
        #1;
        check({tag, ".stall0"}, 32'(stall), 32'd1);
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            start = hold;
            opa = $urandom; opb = $urandom;
            #1;
            if (k < lat) begin
                check({tag, ".stall"}, 32'(stall), 32'd1);
                check({tag, ".ready_early"}, 32'(ready), 32'd0);
                check({tag, ".hi_hold"}, hi, last_hi);
                check({tag, ".lo_hold"}, lo, last_lo);
            end else if (k == lat) begin
                check({tag, ".stall_done"}, 32'(stall), 32'd0);
                check({tag, ".ready"}, 32'(ready), 32'd1);
                check({tag, ".lo"}, lo, eq);
                check({tag, ".hi"}, hi, er);
                seen = 1'b1;
            end
        end
        if (!seen) check({tag, ".timeout"}, 32'd0, 32'd1);
        last_hi = er;
        last_lo = eq;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, ".idle_stall"}, 32'(stall), 32'd0);
        check({tag, ".idle_ready"}, 32'(ready), 32'd0);
        check({tag, ".idle_hi"}, hi, last_hi);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            #1;
            check({tag, ".q_ready"}, 32'(ready), 32'd0);
            check({tag, ".q_stall"}, 32'(stall), 32'd0);
        end
        check({tag, ".q_hi"}, hi, last_hi);
        check({tag, ".q_lo"}, lo, last_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;
        #12;
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
        check("divu_100_7.lo_const", last_lo, 32'd14);
        run_div("div_m8_3", 32'hFFFF_FFF8, 32'd3, 1'b1, 1'b0);
        run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_div("divu_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0);
        run_div("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
        run_div("hold_start", 32'd1000, 32'd10, 1'b0, 1'b1);

        // Flush at iteration 10 (BUSY cycle 11).
        @(negedge clk);
        start = 1'b1; opa = 32'd12345; opb = 32'd17; signed_div = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        annul = 1'b1;
        #1;
        check("annul.ready", 32'(ready), 32'd0);
        @(negedge clk);
        annul = 1'b0;
        expect_quiet("annul", 40);
        run_div("after_annul", 32'd9, 32'd3, 1'b0, 1'b0);

        // start together with annul in IDLE is refused.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opa = 32'd50; opb = 32'd5;
        #1;
        check("st_an.stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        expect_quiet("st_an", 36);

        // Reset at iteration 5.
        @(negedge clk);
        start = 1'b1; opa = 32'd777; opb = 32'd3; signed_div = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        last_hi = '0;
        last_lo = '0;
        check("rst_mid.stall", 32'(stall), 32'd0);
        check("rst_mid.ready", 32'(ready), 32'd0);
        check("rst_mid.hi", hi, 32'd0);
        check("rst_mid.lo", lo, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        expect_quiet("rst_mid", 40);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = {{16{rb[15]}}, rb[15:0]};
                default: ;
            endcase
            if (i == 5) rb = 32'd0;
            run_div($sformatf("rnd%0d", i), ra, rb, rs, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
